// File: rtl/pipe_scene_renderer.sv
// rtl/pipe_scene_renderer.sv - scrolling pipe pairs, bird sprite, collision and score, 2-stage pixel pipeline (optional FLAP_ANIM_EN)
module pipe_scene_renderer #(
    parameter int NUM_PIPES    = 3,
    parameter int PIPE_SPACING = 240,
    parameter int GAP_HEIGHT   = 180,
    parameter int SCROLL_STEP  = 2,
    parameter int GAP_Y_INIT   = 150
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [9:0] row_i,
    input  logic [9:0] col_i,
    input  logic [9:0] bird_y_i,
    input  logic       frame_tick_i,
    input  logic       run_i,
    input  logic       inverted_i,
    input  logic [9:0] new_gap_y_i,
    input  logic       hit_clear_i,
    output logic [7:0] red_o,
    output logic [7:0] green_o,
    output logic [7:0] blue_o,
    output logic       hit_o,
    output logic       score_pulse_o
);

    localparam logic [2:0] C_BLACK  = 3'd0;
    localparam logic [2:0] C_RED    = 3'd1;
    localparam logic [2:0] C_ORANGE = 3'd2;
    localparam logic [2:0] C_YELLOW = 3'd3;
    localparam logic [2:0] C_WHITE  = 3'd4;
    localparam logic [2:0] C_BLUE   = 3'd5;
    localparam logic [2:0] C_GREEN  = 3'd6;
    localparam logic [2:0] C_DGREEN = 3'd7;

    localparam logic [9:0]  STEP10      = 10'(SCROLL_STEP);
    localparam logic [10:0] STEP11      = 11'(SCROLL_STEP);
    localparam logic [9:0]  RESPAWN_ADD = 10'(NUM_PIPES * PIPE_SPACING - SCROLL_STEP);
    localparam logic [10:0] GH          = 11'(GAP_HEIGHT);
    localparam logic [10:0] BIRD_X0     = 11'd312;
    localparam logic [10:0] BIRD_X1     = 11'd328;

    // Flange: 50 columns wide, 30 rows above the gap and 30 rows below it.
    function automatic logic flange_at(input logic [10:0] r, input logic [10:0] c,
                                       input logic [10:0] x, input logic [10:0] g);
        logic fcol;
        logic frow;
        fcol = (c >= x) && (c <= x + 11'd49);
        frow = ((r + 11'd30 >= g) && (r < g)) ||
               ((r >= g + GH) && (r <= g + GH + 11'd29));
        return fcol && frow;
    endfunction

    // Body: narrower than the flange, fills everything above and below the flanges.
    function automatic logic body_at(input logic [10:0] r, input logic [10:0] c,
                                     input logic [10:0] x, input logic [10:0] g);
        logic bcol;
        logic brow;
        bcol = (c >= x + 11'd5) && (c <= x + 11'd34);
        brow = (r + 11'd30 < g) || (r > g + GH + 11'd29);
        return bcol && brow;
    endfunction

    // Bird art in sprite-local coordinates; C_BLUE marks transparent pixels.
    function automatic logic [2:0] sprite_px(input logic [3:0] sr, input logic [4:0] sc,
                                             input logic flap);
        logic [3:0] wing_lo;
        wing_lo = flap ? 4'd4 : 4'd6;
        if (sr >= 4'd6 && sr <= 4'd8 && sc >= 5'd13)
            return C_ORANGE;
        else if (sr == 4'd3 && sc == 5'd11)
            return C_BLACK;
        else if (sr >= 4'd2 && sr <= 4'd4 && sc >= 5'd9 && sc <= 5'd12)
            return C_WHITE;
        else if (sr >= wing_lo && sr <= wing_lo + 4'd2 && sc >= 5'd1 && sc <= 5'd6)
            return C_RED;
        else if (sr >= 4'd1 && sr <= 4'd10 && sc >= 5'd1 && sc <= 5'd12)
            return C_YELLOW;
        else
            return C_BLUE;
    endfunction

    function automatic logic [23:0] palette(input logic [2:0] idx);
        case (idx)
            C_BLACK:  return 24'h000000;
            C_RED:    return 24'hFF0000;
            C_ORANGE: return 24'hFF8000;
            C_YELLOW: return 24'hFFFF00;
            C_WHITE:  return 24'hFFFFFF;
            C_BLUE:   return 24'h00CCFF;
            C_GREEN:  return 24'h00C000;
            default:  return 24'h006000;
        endcase
    endfunction

    logic [9:0]  x_q   [NUM_PIPES];
    logic [9:0]  gap_q [NUM_PIPES];
    logic        score_q;
    logic        hit_q;
    logic        flap;

    logic        s1_flange_q, s1_body_q, s1_opaque_q, s1_inv_q;
    logic [2:0]  s1_idx_q;
    logic [23:0] rgb_q;

    logic        flange_d, body_d, opaque_d, cross_d;
    logic [2:0]  idx_d;
    logic [23:0] rgb_d;
    logic [10:0] r11, c11, by11;

    assign r11  = {1'b0, row_i};
    assign c11  = {1'b0, col_i};
    assign by11 = {1'b0, bird_y_i};

`ifdef FLAP_ANIM_EN
    logic [3:0] frame_cnt_q;

    // Wing animation counter runs on every frame tick, scrolling or not.
    always_ff @(posedge clock_i) begin
        if (reset_i)
            frame_cnt_q <= 4'd0;
        else if (frame_tick_i)
            frame_cnt_q <= frame_cnt_q + 4'd1;
    end

    assign flap = frame_cnt_q[3];
`else
    assign flap = 1'b0;
`endif

    // Stage-1 terms from the current pixel and the current pipe geometry, plus score crossing detect.
    always_comb begin
        flange_d = 1'b0;
        body_d   = 1'b0;
        cross_d  = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            flange_d = flange_d | flange_at(r11, c11, {1'b0, x_q[i]}, {1'b0, gap_q[i]});
            body_d   = body_d   | body_at(r11, c11, {1'b0, x_q[i]}, {1'b0, gap_q[i]});
            cross_d  = cross_d | ((x_q[i] >= STEP10) &&
                                  ({1'b0, x_q[i]} + 11'd50 >= BIRD_X0) &&
                                  ({1'b0, x_q[i]} - STEP11 + 11'd50 < BIRD_X0));
        end
        idx_d    = C_BLUE;
        opaque_d = 1'b0;
        if ((r11 + 11'd6 >= by11) && (r11 + 11'd6 < by11 + 11'd12) &&
            (c11 >= BIRD_X0) && (c11 <= BIRD_X1)) begin
            idx_d    = sprite_px(4'(r11 + 11'd6 - by11), 5'(c11 - BIRD_X0), flap);
            opaque_d = (idx_d != C_BLUE);
        end
    end

    // Stage-2 colour priority: flange, body, bird, background; inversion applies to all.
    always_comb begin
        rgb_d = palette(C_BLUE);
        if (s1_flange_q)
            rgb_d = palette(C_DGREEN);
        else if (s1_body_q)
            rgb_d = palette(C_GREEN);
        else if (s1_opaque_q)
            rgb_d = palette(s1_idx_q);
        if (s1_inv_q)
            rgb_d = ~rgb_d;
    end

    // Pipe scrolling and respawn; x is 10 bits so start positions past 1023 wrap.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_q[i]   <= 10'(640 + i * PIPE_SPACING);
                gap_q[i] <= 10'(GAP_Y_INIT);
            end
            score_q <= 1'b0;
        end else begin
            score_q <= frame_tick_i && run_i && cross_d;
            if (frame_tick_i && run_i) begin
                for (int i = 0; i < NUM_PIPES; i++) begin
                    if (x_q[i] < STEP10) begin
                        x_q[i]   <= x_q[i] + RESPAWN_ADD;
                        gap_q[i] <= new_gap_y_i;
                    end else begin
                        x_q[i] <= x_q[i] - STEP10;
                    end
                end
            end
        end
    end

    // Pixel pipeline registers and the sticky collision flag (set beats clear).
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            s1_flange_q <= 1'b0;
            s1_body_q   <= 1'b0;
            s1_opaque_q <= 1'b0;
            s1_inv_q    <= 1'b0;
            s1_idx_q    <= 3'd0;
            rgb_q       <= 24'd0;
            hit_q       <= 1'b0;
        end else begin
            s1_flange_q <= flange_d;
            s1_body_q   <= body_d;
            s1_opaque_q <= opaque_d;
            s1_inv_q    <= inverted_i;
            s1_idx_q    <= idx_d;
            rgb_q       <= rgb_d;
            hit_q       <= (opaque_d && (flange_d || body_d)) || (hit_q && !hit_clear_i);
        end
    end

    assign red_o         = rgb_q[23:16];
    assign green_o       = rgb_q[15:8];
    assign blue_o        = rgb_q[7:0];
    assign hit_o         = hit_q;
    assign score_pulse_o = score_q;

endmodule

// File: tb/tb_pipe_scene_renderer.sv
// tb/tb_pipe_scene_renderer.sv - randomized scoreboard bench for pipe_scene_renderer
module tb_pipe_scene_renderer;

    localparam int N    = 3;
    localparam int SP   = 240;
    localparam int GH   = 180;
    localparam int STEP = 2;
    localparam int GY   = 150;
    localparam int N2   = 2;
    localparam int SP2  = 0;

    localparam logic [23:0] P_BLACK  = 24'h000000;
    localparam logic [23:0] P_RED    = 24'hFF0000;
    localparam logic [23:0] P_ORANGE = 24'hFF8000;
    localparam logic [23:0] P_YELLOW = 24'hFFFF00;
    localparam logic [23:0] P_WHITE  = 24'hFFFFFF;
    localparam logic [23:0] P_BLUE   = 24'h00CCFF;
    localparam logic [23:0] P_GREEN  = 24'h00C000;
    localparam logic [23:0] P_DGREEN = 24'h006000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] row = '0, col = '0, bird_y = 10'd240, new_gap_y = 10'd150;
    logic       frame_tick = 1'b0, run = 1'b0, inverted = 1'b0, hit_clear = 1'b0;
    logic [7:0] red, green, blue, red2, green2, blue2;
    logic       hit, score_pulse, hit2, score_pulse2;

    always #5 clk = ~clk;

    pipe_scene_renderer #(.NUM_PIPES(N), .PIPE_SPACING(SP), .GAP_HEIGHT(GH),
                          .SCROLL_STEP(STEP), .GAP_Y_INIT(GY)) u_dut (
        .clock_i(clk), .reset_i(reset), .row_i(row), .col_i(col), .bird_y_i(bird_y),
        .frame_tick_i(frame_tick), .run_i(run), .inverted_i(inverted),
        .new_gap_y_i(new_gap_y), .hit_clear_i(hit_clear),
        .red_o(red), .green_o(green), .blue_o(blue), .hit_o(hit), .score_pulse_o(score_pulse));

    // Second instance with coincident pipes, so two pipes cross on the same tick.
    pipe_scene_renderer #(.NUM_PIPES(N2), .PIPE_SPACING(SP2), .GAP_HEIGHT(GH),
                          .SCROLL_STEP(STEP), .GAP_Y_INIT(GY)) u_dut2 (
        .clock_i(clk), .reset_i(reset), .row_i(row), .col_i(col), .bird_y_i(bird_y),
        .frame_tick_i(frame_tick), .run_i(run), .inverted_i(inverted),
        .new_gap_y_i(new_gap_y), .hit_clear_i(hit_clear),
        .red_o(red2), .green_o(green2), .blue_o(blue2), .hit_o(hit2), .score_pulse_o(score_pulse2));

    string art [12] = '{
        ".................",
        ".YYYYYYYYYYYY....",
        ".YYYYYYYYWWWW....",
        ".YYYYYYYYWWKW....",
        ".YYYYYYYYWWWW....",
        ".YYYYYYYYYYYY....",
        ".RRRRRRYYYYYYOOOO",
        ".RRRRRRYYYYYYOOOO",
        ".RRRRRRYYYYYYOOOO",
        ".YYYYYYYYYYYY....",
        ".YYYYYYYYYYYY....",
        "................."
    };

    int mx [N];
    int mg [N];
    int mx2 [N2];
    bit mhit;

    logic [23:0] q_rgb [$];
    logic [2:0]  q_ctl [$];
    bit issued = 1'b0;
    bit v1 = 1'b0, v2 = 1'b0;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] char_rgb(input byte ch);
        case (ch)
            "K":     return P_BLACK;
            "R":     return P_RED;
            "O":     return P_ORANGE;
            "Y":     return P_YELLOW;
            "W":     return P_WHITE;
            default: return P_BLUE;
        endcase
    endfunction

    function automatic bit in_flange(input int r, input int c, input int x, input int g);
        return (c >= x && c <= x + 49) &&
               ((r >= g - 30 && r < g) || (r >= g + GH && r <= g + GH + 29));
    endfunction

    function automatic bit in_body(input int r, input int c, input int x, input int g);
        return (c >= x + 5 && c <= x + 34) && (r < g - 30 || r > g + GH + 29);
    endfunction

    function automatic int next_x(input int x, input int n, input int sp);
        if (x < STEP) return (x + n * sp - STEP) & 1023;
        return x - STEP;
    endfunction

    function automatic bit crosses(input int x);
        return x >= STEP && x + 50 >= 312 && x - STEP + 50 < 312;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = (640 + i * SP) & 1023;
            mg[i] = GY;
        end
        for (int i = 0; i < N2; i++) mx2[i] = (640 + i * SP2) & 1023;
        mhit = 1'b0;
    endtask

    task automatic model_pixel(input int r, input int c, input int by, input bit inv,
                               output logic [23:0] rgb, output bit overlap);
        bit  fl, bd, opq;
        byte ch;
        int  sr, sc;
        fl = 0;
        bd = 0;
        for (int i = 0; i < N; i++) begin
            fl |= in_flange(r, c, mx[i], mg[i]);
            bd |= in_body(r, c, mx[i], mg[i]);
        end
        sr = r - by + 6;
        sc = c - 312;
        ch = ".";
        if (sr >= 0 && sr < 12 && sc >= 0 && sc < 17) ch = art[sr][sc];
        opq = (ch != ".");
        rgb = fl ? P_DGREEN : bd ? P_GREEN : opq ? char_rgb(ch) : P_BLUE;
        if (inv) rgb = ~rgb;
        overlap = opq && (fl || bd);
    endtask

    task automatic do_cycle(input int r, input int c, input int by, input bit inv, input bit clr,
                            input bit tick, input bit rn, input int ng,
                            input bit force_rgb, input logic [23:0] frgb);
        logic [23:0] rgb;
        bit ov, s1, s2;
        @(negedge clk);
        reset = 1'b0;
        row = 10'(r); col = 10'(c); bird_y = 10'(by);
        inverted = inv; hit_clear = clr; frame_tick = tick; run = rn; new_gap_y = 10'(ng);
        issued = 1'b1;
        model_pixel(r, c, by, inv, rgb, ov);
        q_rgb.push_back(force_rgb ? frgb : rgb);
        mhit = ov || (mhit && !clr);
        s1 = 0;
        s2 = 0;
        if (tick && rn) begin
            for (int i = 0; i < N; i++) begin
                s1 |= crosses(mx[i]);
                if (mx[i] < STEP) mg[i] = ng;
                mx[i] = next_x(mx[i], N, SP);
            end
            for (int i = 0; i < N2; i++) begin
                s2 |= crosses(mx2[i]);
                mx2[i] = next_x(mx2[i], N2, SP2);
            end
        end
        q_ctl.push_back({s1, s2, mhit});
    endtask

    task automatic rand_cycle(input bit tick, input bit rn);
        int by, r, c;
        by = 20 + int'($urandom % 440);
        if ($urandom % 2 == 0) begin
            r = by - 6 + int'($urandom % 12);
            c = 312 + int'($urandom % 17);
        end else begin
            r = int'($urandom % 480);
            c = int'($urandom % 640);
        end
        do_cycle(r, c, by, ($urandom % 8) == 0, ($urandom % 4) == 0, tick, rn,
                 60 + int'($urandom % 240), 1'b0, '0);
    endtask

    task automatic reset_cycle(input bit tick);
        @(negedge clk);
        reset = 1'b1;
        frame_tick = tick;
        run = 1'b1;
        issued = 1'b0;
        q_rgb.delete();
        q_ctl.delete();
        model_reset();
        @(posedge clk);
        #1;
        check("reset_rgb", {8'h0, red, green, blue}, 32'h0);
        check("reset_hit", {31'h0, hit}, 32'h0);
        check("reset_score", {31'h0, score_pulse}, 32'h0);
        check("reset_score2", {31'h0, score_pulse2}, 32'h0);
    endtask

    // Scoreboard valid tags follow the fixed output latencies (1 for hit/score, 2 for RGB).
    always @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= issued;
            v2 <= v1;
        end
    end

    // Monitor: pop and compare whatever the DUT presents this cycle.
    always @(posedge clk) begin
        logic [2:0]  ec;
        logic [23:0] er;
        #1;
        if (v1) begin
            if (q_ctl.size() == 0) begin
                check("ctl_queue_underflow", 32'd0, 32'd1);
            end else begin
                ec = q_ctl.pop_front();
                check("score_pulse", {31'h0, score_pulse}, {31'h0, ec[2]});
                check("score_pulse_dual", {31'h0, score_pulse2}, {31'h0, ec[1]});
                check("hit", {31'h0, hit}, {31'h0, ec[0]});
            end
        end
        if (v2) begin
            if (q_rgb.size() == 0) begin
                check("rgb_queue_underflow", 32'd0, 32'd1);
            end else begin
                er = q_rgb.pop_front();
                check("rgb", {8'h0, red, green, blue}, {8'h0, er});
            end
        end
    end

    initial begin
        model_reset();
        reset_cycle(1'b0);
        reset_cycle(1'b0);
        do_cycle(0, 10, 240, 1'b0, 1'b0, 1'b0, 1'b0, 150, 1'b1, P_BLUE);
        do_cycle(0, 10, 240, 1'b1, 1'b0, 1'b0, 1'b0, 150, 1'b1, 24'hFF3300);
        for (int k = 0; k < 100; k++) rand_cycle(1'b1, 1'b1);
        do_cycle(10, 450, 240, 1'b0, 1'b0, 1'b0, 1'b0, 150, 1'b1, P_GREEN);
        do_cycle(140, 442, 240, 1'b0, 1'b0, 1'b0, 1'b0, 150, 1'b1, P_DGREEN);
        for (int k = 0; k < 3000; k++) rand_cycle(($urandom % 3) == 0, ($urandom % 8) != 0);
        reset_cycle(1'b1);
        do_cycle(10, 650, 240, 1'b0, 1'b0, 1'b0, 1'b0, 150, 1'b1, P_GREEN);
        do_cycle(10, 638, 240, 1'b0, 1'b0, 1'b0, 1'b0, 150, 1'b1, P_BLUE);
        for (int k = 0; k < 500; k++) rand_cycle(($urandom % 3) == 0, 1'b1);
        @(negedge clk);
        issued = 1'b0;
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        check("drain_rgb", q_rgb.size(), 32'd0);
        check("drain_ctl", q_ctl.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_scene_renderer.md
PIPE_SCENE_RENDERER -- requirements
Module: pipe_scene_renderer

Interface
REQ-001 The module SHALL have parameter NUM_PIPES, default 3, number of independent scrolling pipe pairs (1..8).
REQ-002 The module SHALL have parameter PIPE_SPACING, default 240, horizontal distance in pixels between adjacent pipe left edges.
REQ-003 The module SHALL have parameter GAP_HEIGHT, default 180, vertical opening in rows between the top and bottom flanges.
REQ-004 The module SHALL have parameter SCROLL_STEP, default 2, pixels moved left per frame_tick.
REQ-005 The module SHALL have parameter GAP_Y_INIT, default 150, gap top row loaded at reset.
REQ-006 clock  input  1  system clock; one clock; all state is updated on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 row, col  input  10 each  current VGA pixel coordinate.
REQ-009 bird_y  input  10  bird centre row.
REQ-010 frame_tick  input  1  one-cycle pulse, once per frame, during blanking.
REQ-011 run  input  1  enables scrolling.
REQ-012 inverted  input  1  selects the inverted palette.
REQ-013 new_gap_y  input  10  gap top row loaded into a respawning pipe.
REQ-014 hit_clear  input  1  clears the collision flag.
REQ-015 red, green, blue  output  8 each  registered pixel colour.
REQ-016 hit  output  1  sticky collision flag.
REQ-017 score_pulse  output  1  one-cycle pulse when the bird passes a pipe.

Function
REQ-018 Each pipe i SHALL hold x_i and gap_i, both 10 bits. The flange spans columns x_i..x_i+49. The body spans columns x_i+5..x_i+34.
REQ-019 Vertical geometry SHALL be:
- top body: rows < gap_i-30
- top flange: rows gap_i-30..gap_i-1
- bottom flange: rows gap_i+GAP_HEIGHT..gap_i+GAP_HEIGHT+29
- bottom body: rows beyond the bottom flange
All comparisons SHALL use 11-bit arithmetic so that no sum wraps.
REQ-020 The bird SHALL be a 12-row by 17-column sprite covering rows bird_y-6..bird_y+5 and columns 312..328, drawn from the team 8-colour palette (BLACK, RED, ORANGE, YELLOW, WHITE, BLUE, GREEN, DGREEN). BLUE in the sprite is transparent.
REQ-021 Colour priority SHALL be: any flange DGREEN, then any body GREEN, then opaque bird pixel, then BLUE background.
REQ-022 Pixel pipeline:
- stage 1 registers the geometry and sprite-hit terms and the sprite colour index
- stage 2 registers the palette-mapped RGB
- latency SHALL be exactly 2 cycles from row/col to RGB
REQ-023 On frame_tick with run=1, each x_i SHALL decrease by SCROLL_STEP. If x_i < SCROLL_STEP, the pipe SHALL respawn instead: x_i <= x_i + NUM_PIPES*PIPE_SPACING - SCROLL_STEP and gap_i <= new_gap_y.
REQ-024 With run=0, x_i and gap_i SHALL hold.
REQ-025 score_pulse SHALL be asserted for exactly one cycle following a frame_tick on which some pipe's x_i+50 goes from >=312 to <312. Multiple pipes crossing on the same tick SHALL produce a single pulse.
REQ-026 hit SHALL set one cycle after stage 1 sees an opaque bird pixel overlapping any flange or body. It SHALL stay set until hit_clear. If set and clear occur in the same cycle, set wins.
REQ-027 Geometry updated by frame_tick SHALL first affect the pixel sampled on the following cycle; pixels already in the pipeline SHALL keep their sampled geometry.

Reset
REQ-028 On reset the following SHALL hold on the next edge, and any scroll or pipeline activity in flight SHALL be discarded:
- red, green, blue = 0
- hit = 0
- score_pulse = 0
- pipeline registers = 0
- x_i = 640 + i*PIPE_SPACING
- gap_i = GAP_Y_INIT

Configuration
REQ-029 Macro FLAP_ANIM_EN defined: a 4-bit frame counter SHALL advance on every frame_tick (including when run=0) and reset to 0. Counter bit 3 SHALL select an alternate wing sprite with the wing rows shifted up by 2.
REQ-030 Macro FLAP_ANIM_EN undefined: the counter SHALL be absent and the wing SHALL be static.

Verification
REQ-031 Reset, then pixel (row 0, col 10) -> RGB 00/CC/FF two cycles later, with hit=0 and score_pulse=0.
REQ-032 NUM_PIPES=3, run=1, 100 frame_ticks -> x_0 = 440. Pixel at (row 10, col 450) -> GREEN; pixel at (row gap_0-10, col 442) -> DGREEN.
REQ-033 x_0=1, frame_tick, new_gap_y=220 -> x_0 = 719, gap_0 = 220.
REQ-034 A pipe crossing x+50 = 311 on a tick -> exactly one score_pulse. Two pipes crossing on the same tick -> one pulse.
REQ-035 bird_y=100 with a pipe over columns 300..349 and gap 200 -> hit rises 1 cycle after the overlapping pixel. hit_clear and overlap in the same cycle -> hit stays 1.
REQ-036 inverted=1, background pixel -> RGB FF/33/00. Reset asserted mid-scroll -> x_0 = 640 on the next edge.
